inst_fetch_unit: RTL and testbench

//  Instruction-supply end of the core's INST/PC interface. Owns the fetch PC and prefetches

---
 rtl/inst_fetch_unit.sv | 109 ++++++++++
 tb/tb_inst_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Sequential instruction prefetcher: owns fetch_pc, issues in-order word reads, buffers into a FIFO.
// Optional FETCH_MISALIGN_CHECK_EN: sticky fault on misaligned redirect instead of masking low bits.
module inst_fetch_unit #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] INST,
  output logic [31:0] inst_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        misalign_fault
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [OW-1:0]   outstanding, drop;
  logic [31:0]     fetch_pc, rsp_pc, redir_pc;
  logic [SW-1:0]   cnt_x, out_x, drop_x;
  logic            accept, pop, push, rsp_drop, rsp_old;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;
  assign redir_pc       = redirect_pc;
  assign misalign_fault = fault_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)               fault_q <= 1'b0;
    else if (redirect_valid) fault_q <= (redirect_pc[1:0] != 2'b00);
  end
`else
  assign redir_pc       = redirect_pc & 32'hFFFF_FFFC;
  assign misalign_fault = 1'b0;
`endif

  assign cnt_x  = SW'(count);
  assign out_x  = SW'(outstanding);
  assign drop_x = SW'(drop);

  // Credits cover FIFO space for every live request, so a push can never overflow.
  assign mem_req_valid = !RESET && !redirect_valid && !misalign_fault &&
                         (cnt_x + out_x < SW'(DEPTH)) &&
                         (out_x + drop_x < SW'(MAX_OUTSTANDING));
  assign mem_req_addr  = fetch_pc;

  assign inst_valid = (count != '0);
  assign INST       = inst_valid ? fifo[rd_ptr].data : 32'h0;
  assign inst_pc    = inst_valid ? fifo[rd_ptr].pc   : 32'h0;

  assign accept   = mem_req_valid && mem_req_ready;
  assign pop      = inst_valid && inst_ready;
  assign rsp_drop = mem_rsp_valid && (drop != '0);
  assign push     = mem_rsp_valid && (drop == '0) && (outstanding != '0);
  // A response landing in a redirect cycle belongs to the old stream; discard it.
  assign rsp_old  = mem_rsp_valid && ((drop != '0) || (outstanding != '0));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redir_pc;
      rsp_pc      <= redir_pc;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= drop + outstanding - OW'(rsp_old);
    end else begin
      if (accept)   fetch_pc <= fetch_pc + 32'd4;
      if (rsp_drop) drop     <= drop - OW'(1);
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      outstanding <= outstanding + OW'(accept) - OW'(push);
      count       <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push && !redirect_valid) fifo[wr_ptr] <= '{pc: rsp_pc, data: mem_rsp_data};
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: in-order memory model with variable latency,
// expected instructions queued at request acceptance and compared at pop.
module tb_inst_fetch_unit;
  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] INST, inst_pc;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        misalign_fault;

  inst_fetch_unit #(.DEPTH(4), .MAX_OUTSTANDING(4), .RESET_PC(32'h0)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .INST(INST), .inst_pc(inst_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .misalign_fault(misalign_fault)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct { int due; logic [31:0] data; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  pend_t       pend [$];
  exp_t        exp_q [$];
  logic [31:0] exp_pc;
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, lat = 1, last_due = 0;
  int          n_acc, n_pop;
  logic [31:0] first_acc, first_pop;
  bit          got_acc, got_pop;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  task automatic clr_stats();
    n_acc = 0; n_pop = 0; got_acc = 0; got_pop = 0;
    first_acc = 32'hx; first_pop = 32'hx;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc1();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = pend[0].data;
      void'(pend.pop_front());
    end
    #1;
    if (!inst_valid) begin
      chk("inst_zero", INST, 32'h0);
      chk("pc_zero", inst_pc, 32'h0);
    end
    if (redirect_valid) chk("redir_noreq", 32'(mem_req_valid), 32'd0);
    if (mem_req_valid && mem_req_ready) begin
      int d;
      chk("req_addr", mem_req_addr, exp_pc);
      d = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = d;
      pend.push_back('{d, memf(mem_req_addr)});
      exp_q.push_back('{mem_req_addr, memf(mem_req_addr)});
      if (!got_acc) begin first_acc = mem_req_addr; got_acc = 1; end
      n_acc++;
      exp_pc = exp_pc + 32'd4;
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("inst_pc", inst_pc, exp_q[0].pc);
        chk("inst", INST, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (!got_pop) begin first_pop = inst_pc; got_pop = 1; end
      n_pop++;
    end
    if (redirect_valid) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      exp_pc = redirect_pc;
`else
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
    end
    @(negedge CLOCK);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc1();
  endtask

  task automatic do_reset();
    RESET = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    inst_ready = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    pend.delete(); exp_q.delete(); exp_pc = 32'h0; last_due = 0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", INST, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", 32'(misalign_fault), 32'd0);
    RESET = 1'b0;
    clr_stats();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    cyc1();
    redirect_valid = 1'b0;
    clr_stats();
  endtask

  initial begin
    bit found;

    // 1: streaming, 1-cycle memory, consumer always ready
    do_reset();
    lat = 1; mem_req_ready = 1; inst_ready = 1;
    run(12);
    chk("t1_first_acc", first_acc, 32'h0);
    chk("t1_first_pop", first_pop, 32'h0);
    chk("t1_pops", 32'(n_pop), 32'd10);

    // 2: stalled consumer fills exactly DEPTH entries
    do_reset();
    lat = 1; mem_req_ready = 1; inst_ready = 0;
    run(10);
    chk("t2_acc", 32'(n_acc), 32'd4);
    chk("t2_req_low", 32'(mem_req_valid), 32'd0);
    chk("t2_head_pc", inst_pc, 32'h0);
    clr_stats();
    inst_ready = 1;
    run(10);
    chk("t2_first_pop", first_pop, 32'h0);
    chk("t2_resume", first_acc, 32'h10);

    // 3: redirect with two requests in flight on a 3-cycle memory
    do_reset();
    lat = 3; mem_req_ready = 1; inst_ready = 1;
    run(2);
    chk("t3_acc", 32'(n_acc), 32'd2);
    redirect(32'h100);
    run(15);
    chk("t3_first_acc", first_acc, 32'h100);
    chk("t3_first_pop", first_pop, 32'h100);

    // 4: redirect coincident with a response and a pop
    do_reset();
    lat = 1; mem_req_ready = 1; inst_ready = 1;
    run(4);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc && inst_valid) found = 1;
      else cyc1();
    end
    chk("t4_setup", 32'(found), 32'd1);
    redirect(32'h200);
    chk("t4_empty", 32'(inst_valid), 32'd0);
    run(8);
    chk("t4_first_pop", first_pop, 32'h200);

    // 5: memory backpressure holds the request steady
    do_reset();
    lat = 2; mem_req_ready = 0; inst_ready = 1;
    redirect(32'h40);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_hold_valid", 32'(mem_req_valid), 32'd1);
      chk("t5_hold_addr", mem_req_addr, 32'h40);
      cyc1();
    end
    mem_req_ready = 1;
    run(8);
    chk("t5_first_acc", first_acc, 32'h40);
    chk("t5_first_pop", first_pop, 32'h40);

    // 6: misaligned redirect
    do_reset();
    lat = 1; mem_req_ready = 1; inst_ready = 1;
    run(3);
    redirect(32'h102);
    run(5);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("t6_fault_set", 32'(misalign_fault), 32'd1);
    chk("t6_no_req", 32'(n_acc), 32'd0);
    redirect(32'h200);
    chk("t6_fault_clr", 32'(misalign_fault), 32'd0);
    run(6);
    chk("t6_first_acc", first_acc, 32'h200);
`else
    chk("t6_fault_tied", 32'(misalign_fault), 32'd0);
    chk("t6_first_acc", first_acc, 32'h100);
    chk("t6_first_pop", first_pop, 32'h100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
